// File: rtl/i2s_master_tx.sv
// ---------------------------------------------------------------------------
// i2s_master_tx
//   I2S clock-master transmitter. Generates BCLK and LRCLK from clk and
//   serialises stereo sample pairs onto sdata. Samples are offered through a
//   one-entry valid/ready holding register. The holding register is copied
//   into the transmit registers once per frame, at the load point.
//
// Parameters
//   BITSIZE   : sample width, two's complement (BITSIZE <= SLOT_BITS-2)
//   SLOT_BITS : BCLK periods per channel slot (power of two)
//   BCLK_DIV  : clk cycles per BCLK half-period (>= 1)
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   left_in     in   left sample
//   right_in    in   right sample
//   in_valid    in   sample pair valid
//   in_ready    out  holding register empty
//   bclk        out  bit clock
//   lrclk       out  word select (0 = left, 1 = right)
//   sdata       out  serial data, changes on BCLK falling edges
//   frame_start out  one-clk pulse when the left slot begins
//   underrun    out  one-clk pulse with frame_start when no new pair was loaded
//
// Build option
//   I2S_MASTER_TX_LEFT_JUSTIFIED_EN : left-justified format (the MSB is
//   coincident with the lrclk edge). When undefined, the block uses standard
//   I2S with a one-bit delay.
// ---------------------------------------------------------------------------
module i2s_master_tx #(
  parameter int BITSIZE   = 16,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITSIZE-1:0] left_in,
  input  logic [BITSIZE-1:0] right_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic               frame_start,
  output logic               underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int SLOT_W     = $clog2(SLOT_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  // bit_cnt value just before the load point (the load point is FRAME_BITS-1).
  localparam logic [CNT_W-1:0] LOAD_PREV = CNT_W'(FRAME_BITS - 2);
  localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(FRAME_BITS - 2);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               bclk_q, bclk_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic               frame_start_q, frame_start_d;
  logic               underrun_q, underrun_d;
  logic               pend_q, pend_d;          // last load found the hold register empty
  logic               hold_full_q, hold_full_d;
  logic [BITSIZE-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [BITSIZE-1:0] cur_l_q, cur_l_d, cur_r_q, cur_r_d;

  logic               div_tc, fall, load, accept;
  logic [CNT_W-1:0]   bit_nxt;
  logic [SLOT_W-1:0]  slot_k;
  logic [BITSIZE-1:0] sample;
  logic [SLOT_BITS-1:0] slot_vec;

  always_comb begin
    div_tc  = (div_cnt_q == DIV_LAST);
    fall    = div_tc && bclk_q;
    bit_nxt = bit_cnt_q + CNT_W'(1);   // SLOT_BITS is a power of two, so this wraps mod frame
    load    = fall && (bit_cnt_q == LOAD_PREV);
    accept  = in_valid && !hold_full_q;
    slot_k  = bit_nxt[SLOT_W-1:0];
    sample  = bit_nxt[CNT_W-1] ? cur_r_q : cur_l_q;
    // Slot image with slot bit k at position SLOT_BITS-1-k, which is ~k in
    // SLOT_W bits.
`ifdef I2S_MASTER_TX_LEFT_JUSTIFIED_EN
    slot_vec = {sample, {(SLOT_BITS - BITSIZE){1'b0}}};
`else
    slot_vec = {1'b0, sample, {(SLOT_BITS - 1 - BITSIZE){1'b0}}};
`endif

    div_cnt_d     = div_tc ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d        = div_tc ? ~bclk_q : bclk_q;
    bit_cnt_d     = bit_cnt_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    pend_d        = pend_q;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    cur_l_d       = cur_l_q;
    cur_r_d       = cur_r_q;

    if (fall) begin
      bit_cnt_d     = bit_nxt;
      lrclk_d       = bit_nxt[CNT_W-1];
      sdata_d       = slot_vec[~slot_k];
      frame_start_d = (bit_nxt == '0);
      underrun_d    = (bit_nxt == '0) && pend_q;
    end

    // The load lands on right-slot bit SLOT_BITS-1, which is always padding.
    // Replacing cur_r here therefore cannot corrupt a transmitted bit.
    if (load) begin
      if (hold_full_q) begin
        cur_l_d     = hold_l_q;
        cur_r_d     = hold_r_q;
        hold_full_d = 1'b0;
        pend_d      = 1'b0;
      end else begin
        pend_d      = 1'b1;
      end
    end

    // accept needs the hold register to be empty, so it never collides with a
    // load that drains a full hold register.
    if (accept) begin
      hold_l_d    = left_in;
      hold_r_d    = right_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= CNT_RST;
      lrclk_q       <= 1'b1;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      pend_q        <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      cur_l_q       <= '0;
      cur_r_q       <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      pend_q        <= pend_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      cur_l_q       <= cur_l_d;
      cur_r_q       <= cur_r_d;
    end
  end

  assign in_ready    = !hold_full_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_master_tx
//   Self-checking bench for i2s_master_tx. A timing model derives the expected
//   bclk, lrclk, frame_start and bit position from the clk count since reset.
//   Accepted pairs are pushed to a scoreboard queue. At each load point, the
//   head entry of the queue becomes the expected frame content, or an underrun
//   is expected when the queue is empty. Every clk cycle, the bench compares
//   all outputs against this model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_master_tx;

  localparam int BITSIZE   = 16;
  localparam int SLOT_BITS = 32;
  localparam int BCLK_DIV  = 8;
  localparam int FRAME     = 2 * SLOT_BITS;          // bits per frame
  localparam int FRAME_CLK = FRAME * 2 * BCLK_DIV;   // clk cycles per frame

  logic clk, rst, in_valid;
  logic [BITSIZE-1:0] left_in, right_in;
  logic in_ready, bclk, lrclk, sdata, frame_start, underrun;

  i2s_master_tx #(.BITSIZE(BITSIZE), .SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV)) dut (
    .clk(clk), .rst(rst), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected serial bit for slot bit k of sample s.
  function automatic logic exp_bit(input logic [BITSIZE-1:0] s, input int k);
`ifdef I2S_MASTER_TX_LEFT_JUSTIFIED_EN
    if (k <= BITSIZE - 1) return s[BITSIZE-1-k];
`else
    if (k >= 1 && k <= BITSIZE) return s[BITSIZE-k];
`endif
    return 1'b0;
  endfunction

  // Reference model state.
  int cyc = 0;
  int acc_cnt = 0;
  int frame_no = 0;
  logic [2*BITSIZE-1:0] sb_q[$];
  logic [BITSIZE-1:0] cur_l_m = '0, cur_r_m = '0;
  logic pend_m = 1'b0;

  always @(posedge clk) begin
    int bc, k;
    logic ready_before, fall, fs_exp, ur_exp;
    logic [BITSIZE-1:0] samp;
    if (rst) begin
      cyc = 0;
      sb_q.delete();
      cur_l_m = '0;
      cur_r_m = '0;
      pend_m = 1'b0;
    end else begin
      cyc++;
      ready_before = (sb_q.size() == 0);
      fall = (cyc % (2 * BCLK_DIV)) == 0;
      bc = (FRAME - 2 + cyc / (2 * BCLK_DIV)) % FRAME;
      if (fall && bc == FRAME - 1) begin
        if (sb_q.size() > 0) begin
          {cur_l_m, cur_r_m} = sb_q.pop_front();
          pend_m = 1'b0;
        end else begin
          pend_m = 1'b1;
        end
      end
      fs_exp = fall && (bc == 0);
      ur_exp = fs_exp && pend_m;
      if (fs_exp) begin
        frame_no++;
        $display("frame %0d: L=%h R=%h underrun=%0d", frame_no, cur_l_m, cur_r_m, ur_exp);
      end
      if (in_valid && ready_before) begin
        sb_q.push_back({left_in, right_in});
        acc_cnt++;
      end
      k = bc % SLOT_BITS;
      samp = (bc < SLOT_BITS) ? cur_l_m : cur_r_m;
      #1;
      check_val("bclk", 32'(bclk), 32'((cyc / BCLK_DIV) % 2));
      check_val("lrclk", 32'(lrclk), 32'(bc >= SLOT_BITS));
      check_val("frame_start", 32'(frame_start), 32'(fs_exp));
      check_val("underrun", 32'(underrun), 32'(ur_exp));
      check_val("in_ready", 32'(in_ready), 32'(sb_q.size() == 0));
      check_val("sdata", 32'(sdata), 32'(exp_bit(samp, k)));
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    #1;
    check_val("rst_bclk", 32'(bclk), 32'd0);
    check_val("rst_lrclk", 32'(lrclk), 32'd1);
    check_val("rst_sdata", 32'(sdata), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_frame_start", 32'(frame_start), 32'd0);
    check_val("rst_underrun", 32'(underrun), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer a pair and keep in_valid high until the model records its acceptance.
  task automatic offer(input logic [BITSIZE-1:0] l, input logic [BITSIZE-1:0] r);
    int start;
    bit done;
    start = acc_cnt;
    done = 1'b0;
    in_valid = 1'b1;
    left_in = l;
    right_in = r;
    for (int i = 0; i < 3 * FRAME_CLK && !done; i++) begin
      @(negedge clk);
      if (acc_cnt != start) done = 1'b1;
    end
    if (!done) check_val("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_phase(input int ph);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3 * FRAME_CLK && !done; i++) begin
      @(negedge clk);
      if ((cyc % FRAME_CLK) == ph && sb_q.size() == 0) done = 1'b1;
    end
    if (!done) check_val("phase_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    left_in = '0;
    right_in = '0;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // No input: check clocking only, with sdata 0 and an underrun every frame.
    run_cycles(3 * FRAME_CLK + 40);

    // Basic serialisation: a pair accepted before the first load.
    do_reset();
    offer(16'hA5C3, 16'h8001);
    in_valid = 1'b0;
    run_cycles(2 * FRAME_CLK + 100);

    // Backpressure: three pairs offered back to back.
    offer(16'h1234, 16'h5678);
    offer(16'h9ABC, 16'hDEF0);
    offer(16'h0F0F, 16'hF0F0);
    in_valid = 1'b0;
    run_cycles(3 * FRAME_CLK);

    // Underrun repeat.
    offer(16'h7FFF, 16'h0001);
    in_valid = 1'b0;
    run_cycles(4 * FRAME_CLK);

    // Pair presented exactly in the load-point cycle while hold is empty.
    wait_phase(2 * BCLK_DIV - 1);
    offer(16'hC0DE, 16'h3A5A);
    in_valid = 1'b0;
    run_cycles(3 * FRAME_CLK);

    // Asynchronous reset mid-right-slot while hold is full; pending pair discarded.
    wait_phase(600);
    offer(16'hFFFF, 16'hFFFF);
    in_valid = 1'b0;
    while ((cyc % FRAME_CLK) != 700) @(negedge clk);
    rst = 1'b1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_cycles(2 * FRAME_CLK + 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
